// File: rtl/cs_pkg.sv
// Shared constants and types for the (2,3) cyclic-shift MDS encoder/decoder pair.
package cs_pkg;

  localparam int unsigned N_CODED  = 3;
  localparam int unsigned K_DATA   = 2;
  // Rotation amounts applied to data_0/data_1 when forming parity; the decoder undoes them.
  localparam int unsigned SHIFT_D0 = 1;
  localparam int unsigned SHIFT_D1 = 2;

  typedef enum logic [1:0] {IDLE, S0, S1, S2} enc_state_t;

  typedef logic [1:0] sym_idx_t;

endpackage

// File: rtl/cs_parity_2_3.sv
// Combinational parity for the (2,3) code: rotl(data_0,1) ^ rotl(data_1,2).
module cs_parity_2_3
  import cs_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_0,
  input  logic [WIDTH-1:0] data_1,
  output logic [WIDTH-1:0] parity
);

  logic [WIDTH-1:0] rot_d0;
  logic [WIDTH-1:0] rot_d1;

  cyclic_shift #(
    .WIDTH    (WIDTH),
    .SHIFT_AMT(SHIFT_D0)
  ) u_shift_d0 (
    .din (data_0),
    .dout(rot_d0)
  );

  cyclic_shift #(
    .WIDTH    (WIDTH),
    .SHIFT_AMT(SHIFT_D1)
  ) u_shift_d1 (
    .din (data_1),
    .dout(rot_d1)
  );

  assign parity = rot_d0 ^ rot_d1;

endmodule

// File: rtl/cyclic_shift.sv
// Fixed left rotation of a symbol by SHIFT_AMT bit positions.
module cyclic_shift #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned SHIFT_AMT = 1
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = {din[WIDTH-1-SHIFT_AMT:0], din[WIDTH-1:WIDTH-SHIFT_AMT]};

endmodule

// File: rtl/cs_encoder_2_3_stream.sv
// Streaming systematic (2,3) encoder: accepts two data symbols per handshake and
// serialises data_0, data_1, parity onto one valid/ready symbol channel.
module cs_encoder_2_3_stream
  import cs_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_0,
  input  logic [WIDTH-1:0] data_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_symbol,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic [CNT_W-1:0] blk_cnt
);

  enc_state_t       state_q;
  logic [WIDTH-1:0] h_d0_q;
  logic [WIDTH-1:0] h_d1_q;
  logic [WIDTH-1:0] h_par_q;
  logic [WIDTH-1:0] parity;
  logic             accept;

  cs_parity_2_3 #(
    .WIDTH(WIDTH)
  ) u_parity (
    .data_0(data_0),
    .data_1(data_1),
    .parity(parity)
  );

  // The final symbol's cycle doubles as the accept slot for the next block.
  assign in_ready = (state_q == IDLE) || ((state_q == S2) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      h_d0_q    <= '0;
      h_d1_q    <= '0;
      h_par_q   <= '0;
      out_valid <= 1'b0;
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      if (accept) begin
        h_d0_q  <= data_0;
        h_d1_q  <= data_1;
        h_par_q <= parity;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q   <= S0;
            out_valid <= 1'b1;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
          end
        end
        S0: begin
          if (out_ready) begin
            state_q <= S1;
            out_idx <= 2'd1;
          end
        end
        S1: begin
          if (out_ready) begin
            state_q  <= S2;
            out_idx  <= 2'd2;
            out_last <= 1'b1;
          end
        end
        S2: begin
          if (out_ready) begin
            blk_cnt  <= blk_cnt + CNT_W'(1);
            out_idx  <= 2'd0;
            out_last <= 1'b0;
            if (in_valid) begin
              state_q <= S0;
            end else begin
              state_q   <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          out_idx   <= 2'd0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

  // Symbol select is purely from holding registers and the registered index.
  always_comb begin
    out_symbol = '0;
    if (out_valid) begin
      case (out_idx)
        2'd0:    out_symbol = h_d0_q;
        2'd1:    out_symbol = h_d1_q;
        default: out_symbol = h_par_q;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_encoder_2_3_stream.sv
// Directed table plus hand sequences and a scoreboarded random stream for the encoder.
module tb_cs_encoder_2_3_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] data_0;
  logic [3:0] data_1;
  logic       out_ready;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_symbol;
  logic [1:0] out_idx;
  logic       out_last;
  logic [15:0] blk_cnt;

  logic       w_in_ready;
  logic       w_out_valid;
  logic [3:0] w_out_symbol;
  logic [1:0] w_out_idx;
  logic       w_out_last;
  logic [1:0] w_blk_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cs_encoder_2_3_stream #(
    .WIDTH(4),
    .CNT_W(16)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_0    (data_0),
    .data_1    (data_1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_symbol(out_symbol),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .blk_cnt   (blk_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used to observe wrap.
  cs_encoder_2_3_stream #(
    .WIDTH(4),
    .CNT_W(2)
  ) u_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .data_0    (data_0),
    .data_1    (data_1),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_symbol(w_out_symbol),
    .out_idx   (w_out_idx),
    .out_last  (w_out_last),
    .blk_cnt   (w_blk_cnt)
  );

  typedef struct {
    logic       iv;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       ordy;
    logic       ov;
    logic [3:0] sym;
    logic [1:0] idx;
    logic       last;
    logic       irdy;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [3:0] d0, logic [3:0] d1, logic ordy, logic ov,
                              logic [3:0] sym, logic [1:0] idx, logic last, logic irdy, int cnt);
    vec_t v;
    v.iv = iv; v.d0 = d0; v.d1 = d1; v.ordy = ordy; v.ov = ov;
    v.sym = sym; v.idx = idx; v.last = last; v.irdy = irdy; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [3:0] rotl(logic [3:0] x, int s);
    logic [7:0] dbl;
    dbl = {x, x} << s;
    return dbl[7:4];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [3:0] sym_q[$];
  logic [1:0] idx_q[$];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_0    = 4'h0;
    data_1    = 4'h0;
    out_ready = 1'b0;

    //        iv d0       d1       ordy ov sym      idx last irdy cnt
    // single block 0001/0001 -> parity 0110
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 1, 0, 4'b0000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b0001, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b0001, 1, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b0110, 2, 1, 1, 0));
    // back-to-back: 1010/0011 (par 1001) then 1111/0000 (par 1111)
    vecs.push_back(mk(1, 4'b1010, 4'b0011, 1, 0, 4'b0000, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'b1111, 4'b0000, 1, 1, 4'b1010, 0, 0, 0, 1));
    vecs.push_back(mk(1, 4'b1111, 4'b0000, 1, 1, 4'b0011, 1, 0, 0, 1));
    vecs.push_back(mk(1, 4'b1111, 4'b0000, 1, 1, 4'b1001, 2, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b1111, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 1, 0, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b1111, 2, 1, 1, 2));
    // backpressure: 0101/0110 (par 0011), stall in idx1 and idx2, junk data offered
    vecs.push_back(mk(1, 4'b0101, 4'b0110, 1, 0, 4'b0000, 0, 0, 1, 3));
    vecs.push_back(mk(1, 4'b1100, 4'b1100, 1, 1, 4'b0101, 0, 0, 0, 3));
    vecs.push_back(mk(1, 4'b1100, 4'b1100, 0, 1, 4'b0110, 1, 0, 0, 3));
    vecs.push_back(mk(1, 4'b1100, 4'b1100, 0, 1, 4'b0110, 1, 0, 0, 3));
    vecs.push_back(mk(1, 4'b1100, 4'b1100, 0, 1, 4'b0110, 1, 0, 0, 3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b0110, 1, 0, 0, 3));
    vecs.push_back(mk(1, 4'b1000, 4'b0001, 0, 1, 4'b0011, 2, 1, 0, 3));
    // S2 with out_ready: 1000/0001 (par 0101) accepted in the same edge
    vecs.push_back(mk(1, 4'b1000, 4'b0001, 1, 1, 4'b0011, 2, 1, 1, 3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b1000, 0, 0, 0, 4));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b0001, 1, 0, 0, 4));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b0101, 2, 1, 1, 4));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 1, 5));

    // reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_symbol", 32'(out_symbol), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      in_valid  = vecs[i].iv;
      data_0    = vecs[i].d0;
      data_1    = vecs[i].d1;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d_out_symbol", i), 32'(out_symbol), 32'(vecs[i].sym));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].irdy));
      chk($sformatf("v%0d_blk_cnt", i), 32'(blk_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_wrap_cnt", i), 32'(w_blk_cnt), 32'(vecs[i].cnt % 4));
      if (vecs[i].ov) begin
        chk($sformatf("v%0d_out_idx", i), 32'(out_idx), 32'(vecs[i].idx));
        chk($sformatf("v%0d_out_last", i), 32'(out_last), 32'(vecs[i].last));
      end
      @(posedge clk);
      #1;
    end

    // async reset while in S1
    in_valid = 1'b1; data_0 = 4'b0011; data_1 = 4'b0101; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_idx", 32'(out_idx), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_blk_cnt", 32'(blk_cnt), 32'd0);
    chk("async_wrap_cnt", 32'(w_blk_cnt), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_out_symbol", 32'(out_symbol), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1; data_0 = 4'b0001; data_1 = 4'b0010;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_sym0", 32'({out_valid, out_idx, out_symbol}), 32'({1'b1, 2'd0, 4'b0001}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_sym1", 32'({out_valid, out_idx, out_symbol}), 32'({1'b1, 2'd1, 4'b0010}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_sym2", 32'({out_last, out_idx, out_symbol}), 32'({1'b1, 2'd2, 4'b1010}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_blk_cnt", 32'(blk_cnt), 32'd1);
    @(posedge clk); #1;

    // random stream with scoreboard; bounded drain afterwards
    for (int cyc = 0; cyc < 230; cyc++) begin
      if (cyc < 200) begin
        in_valid  = ($urandom_range(0, 1) == 1);
        data_0    = 4'($urandom);
        data_1    = 4'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sym_q.size() == 0) begin
          chk("rand_unexpected_symbol", 32'(out_valid), 32'd0);
        end else begin
          chk("rand_symbol", 32'(out_symbol), 32'(sym_q.pop_front()));
          chk("rand_idx", 32'(out_idx), 32'(idx_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        sym_q.push_back(data_0);
        sym_q.push_back(data_1);
        sym_q.push_back(rotl(data_0, 1) ^ rotl(data_1, 2));
        idx_q.push_back(2'd0);
        idx_q.push_back(2'd1);
        idx_q.push_back(2'd2);
      end
      @(posedge clk);
      #1;
    end
    chk("rand_drain_empty", 32'(sym_q.size()), 32'd0);
    chk("rand_idle_at_end", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
